// File: rtl/alarm_bank.sv
// Bank of N independent BCD alarms with a validated field-write port, auto-stop ringing,
// bounded snooze and global stop.
module alarm_bank #(
    parameter int N_ALARMS    = 5,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3,
    parameter int IDX_W       = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick_1s,
    input  logic [7:0]          cur_hour,
    input  logic [7:0]          cur_min,
    input  logic [7:0]          cur_sec,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [1:0]          wr_field,
    input  logic [7:0]          wr_data,
    output logic                wr_err,
    input  logic [N_ALARMS-1:0] alarm_en,
    input  logic                snooze,
    input  logic                stop,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [7:0]          rd_hour,
    output logic [7:0]          rd_min,
    output logic [7:0]          rd_sec,
    output logic [N_ALARMS-1:0] ringing,
    output logic [N_ALARMS-1:0] snoozed
);

    localparam int CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int SC_W    = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);

    localparam logic [CNT_W-1:0] RING_LD   = CNT_W'(RING_SECS);
    localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_SECS);
    localparam logic [SC_W-1:0]  MAX_SC    = SC_W'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } state_t;

    logic [7:0] hour_reg [N_ALARMS];
    logic [7:0] min_reg  [N_ALARMS];
    logic [7:0] sec_reg  [N_ALARMS];
    logic       wr_err_reg;
    logic       wr_ok;
    logic [7:0] wr_lim;

    always_comb begin
        wr_lim = (wr_field == 2'd0) ? 8'h23 : 8'h59;
        wr_ok  = wr_en
              && (32'(wr_idx) < N_ALARMS)
              && (wr_field != 2'b11)
              && (wr_data[7:4] <= 4'd9)
              && (wr_data[3:0] <= 4'd9)
              && (wr_data <= wr_lim);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_err_reg <= 1'b0;
            for (int i = 0; i < N_ALARMS; i++) begin
                hour_reg[i] <= 8'h00;
                min_reg[i]  <= 8'h00;
                sec_reg[i]  <= 8'h00;
            end
        end else begin
            wr_err_reg <= wr_en && !wr_ok;
            for (int i = 0; i < N_ALARMS; i++) begin
                if (wr_ok && (wr_idx == IDX_W'(i))) begin
                    case (wr_field)
                        2'd0:    hour_reg[i] <= wr_data;
                        2'd1:    min_reg[i]  <= wr_data;
                        default: sec_reg[i]  <= wr_data;
                    endcase
                end
            end
        end
    end

    assign wr_err = wr_err_reg;

    // Out-of-range readback indices fall through to zero.
    always_comb begin
        rd_hour = 8'h00;
        rd_min  = 8'h00;
        rd_sec  = 8'h00;
        for (int i = 0; i < N_ALARMS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_hour = hour_reg[i];
                rd_min  = min_reg[i];
                rd_sec  = sec_reg[i];
            end
        end
    end

    for (genvar gi = 0; gi < N_ALARMS; gi++) begin : g_ch
        state_t           state_reg, state_next;
        logic [CNT_W-1:0] cnt_reg, cnt_next;
        logic [SC_W-1:0]  sc_reg, sc_next;
        logic             match;
        logic             wr_hit;

        assign match  = ({cur_hour, cur_min, cur_sec} == {hour_reg[gi], min_reg[gi], sec_reg[gi]});
        assign wr_hit = wr_ok && (wr_idx == IDX_W'(gi));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
                sc_reg    <= '0;
            end else begin
                state_reg <= state_next;
                cnt_reg   <= cnt_next;
                sc_reg    <= sc_next;
            end
        end

        // Priority: arm switch low > write to this channel > stop > snooze > tick.
        always_comb begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            sc_next    = sc_reg;
            if (!alarm_en[gi] || wr_hit) begin
                state_next = IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (tick_1s && match) begin
                            state_next = RINGING;
                            cnt_next   = RING_LD;
                            sc_next    = '0;
                        end
                    end
                    RINGING: begin
                        if (stop) begin
                            state_next = IDLE;
                        end else if (snooze && (sc_reg < MAX_SC)) begin
                            state_next = SNOOZED;
                            cnt_next   = SNOOZE_LD;
                            sc_next    = sc_reg + SC_W'(1);
                        end else if (tick_1s) begin
                            if (cnt_reg <= CNT_W'(1)) begin
                                state_next = IDLE;
                                cnt_next   = '0;
                            end else begin
                                cnt_next = cnt_reg - CNT_W'(1);
                            end
                        end
                    end
                    SNOOZED: begin
                        if (stop) begin
                            state_next = IDLE;
                        end else if (tick_1s) begin
                            if (cnt_reg <= CNT_W'(1)) begin
                                state_next = RINGING;
                                cnt_next   = RING_LD;
                            end else begin
                                cnt_next = cnt_reg - CNT_W'(1);
                            end
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end

        assign ringing[gi] = (state_reg == RINGING);
        assign snoozed[gi] = (state_reg == SNOOZED);
    end

endmodule

// File: tb/tb_alarm_bank.sv
// Self-checking bench for alarm_bank: write-validation vector table, hand sequences for
// ring/snooze/stop/reset corners, and a randomized run against a behavioural model.
module tb_alarm_bank;

    localparam int N     = 5;
    localparam int IDX_W = 3;
    localparam int RING  = 60;
    localparam int SNZ   = 300;
    localparam int MAXS  = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             tick_1s = 1'b0;
    logic [7:0]       cur_hour = 8'h00, cur_min = 8'h00, cur_sec = 8'h00;
    logic             wr_en = 1'b0;
    logic [IDX_W-1:0] wr_idx = '0;
    logic [1:0]       wr_field = 2'd0;
    logic [7:0]       wr_data = 8'h00;
    logic             wr_err;
    logic [N-1:0]     alarm_en = '0;
    logic             snooze = 1'b0;
    logic             stop = 1'b0;
    logic [IDX_W-1:0] rd_idx = '0;
    logic [7:0]       rd_hour, rd_min, rd_sec;
    logic [N-1:0]     ringing, snoozed;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alarm_bank #(
        .N_ALARMS(N), .RING_SECS(RING), .SNOOZE_SECS(SNZ), .MAX_SNOOZE(MAXS), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .reset(reset), .tick_1s(tick_1s),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_field(wr_field), .wr_data(wr_data), .wr_err(wr_err),
        .alarm_en(alarm_en), .snooze(snooze), .stop(stop),
        .rd_idx(rd_idx), .rd_hour(rd_hour), .rd_min(rd_min), .rd_sec(rd_sec),
        .ringing(ringing), .snoozed(snoozed)
    );

    // Behavioural model: state 0=idle, 1=ringing, 2=snoozed; seconds left in current phase.
    int m_t [N][3];
    int m_st [N];
    int m_left [N];
    int m_sn [N];
    bit m_err;

    function automatic bit bcd_ok(logic [7:0] d, int lim);
        return (d[7:4] <= 9) && (d[3:0] <= 9) && (int'(d) <= lim);
    endfunction

    function automatic bit write_ok(int idx, int field, logic [7:0] d);
        if (idx >= N || field == 3) return 1'b0;
        return bcd_ok(d, (field == 0) ? 'h23 : 'h59);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_t[i][0] = 0; m_t[i][1] = 0; m_t[i][2] = 0;
            m_st[i] = 0; m_left[i] = 0; m_sn[i] = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic model_edge();
        bit ok;
        ok = wr_en && write_ok(int'(wr_idx), int'(wr_field), wr_data);
        for (int i = 0; i < N; i++) begin
            if (!alarm_en[i]) m_st[i] = 0;
            else if (ok && int'(wr_idx) == i) m_st[i] = 0;
            else if (m_st[i] != 0 && stop) m_st[i] = 0;
            else if (m_st[i] == 1 && snooze && m_sn[i] < MAXS) begin
                m_st[i] = 2; m_left[i] = SNZ; m_sn[i]++;
            end else if (tick_1s) begin
                if (m_st[i] == 0) begin
                    if (int'(cur_hour) == m_t[i][0] && int'(cur_min) == m_t[i][1]
                        && int'(cur_sec) == m_t[i][2]) begin
                        m_st[i] = 1; m_left[i] = RING; m_sn[i] = 0;
                    end
                end else begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        if (m_st[i] == 1) m_st[i] = 0;
                        else begin m_st[i] = 1; m_left[i] = RING; end
                    end
                end
            end
        end
        if (ok) m_t[int'(wr_idx)][int'(wr_field)] = int'(wr_data);
        m_err = wr_en && !ok;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic [N-1:0] r_e, s_e;
        logic [23:0]  rd_e;
        for (int i = 0; i < N; i++) begin
            r_e[i] = (m_st[i] == 1);
            s_e[i] = (m_st[i] == 2);
        end
        rd_e = '0;
        if (int'(rd_idx) < N)
            rd_e = {8'(m_t[int'(rd_idx)][0]), 8'(m_t[int'(rd_idx)][1]), 8'(m_t[int'(rd_idx)][2])};
        chk("model_ringing", 32'(ringing), 32'(r_e));
        chk("model_snoozed", 32'(snoozed), 32'(s_e));
        chk("model_wr_err", 32'(wr_err), 32'(m_err));
        chk("model_rd", 32'({rd_hour, rd_min, rd_sec}), 32'(rd_e));
    endtask

    // One clock: model advances on the same inputs, outputs sampled 1 ns after the edge.
    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic wr(int idx, int field, logic [7:0] d);
        wr_en = 1'b1; wr_idx = IDX_W'(idx); wr_field = 2'(field); wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic tick_at(logic [7:0] h, logic [7:0] m, logic [7:0] s);
        cur_hour = h; cur_min = m; cur_sec = s; tick_1s = 1'b1;
        cyc();
        tick_1s = 1'b0;
    endtask

    task automatic ticks(int n);
        for (int k = 0; k < n; k++) tick_at(8'h23, 8'h59, 8'h58);
    endtask

    task automatic set_alarm(int idx, logic [7:0] h, logic [7:0] m, logic [7:0] s);
        wr(idx, 0, h); wr(idx, 1, m); wr(idx, 2, s);
    endtask

    typedef struct {
        int         idx;
        int         field;
        logic [7:0] data;
        logic       exp_err;
        int         rdi;
        logic [23:0] exp_rd;
    } wvec_t;

    wvec_t wv [13];

    initial begin
        wv[0]  = '{2, 0, 8'h07, 1'b0, 2, 24'h070000};
        wv[1]  = '{2, 1, 8'h30, 1'b0, 2, 24'h073000};
        wv[2]  = '{2, 2, 8'h00, 1'b0, 2, 24'h073000};
        wv[3]  = '{1, 0, 8'h24, 1'b1, 1, 24'h000000};
        wv[4]  = '{1, 1, 8'h5A, 1'b1, 1, 24'h000000};
        wv[5]  = '{5, 0, 8'h07, 1'b1, 1, 24'h000000};
        wv[6]  = '{1, 3, 8'h12, 1'b1, 1, 24'h000000};
        wv[7]  = '{1, 0, 8'h1A, 1'b1, 1, 24'h000000};
        wv[8]  = '{1, 0, 8'h23, 1'b0, 1, 24'h230000};
        wv[9]  = '{1, 1, 8'h59, 1'b0, 1, 24'h235900};
        wv[10] = '{1, 2, 8'h60, 1'b1, 1, 24'h235900};
        wv[11] = '{1, 0, 8'h00, 1'b0, 1, 24'h005900};
        wv[12] = '{7, 1, 8'h11, 1'b1, 7, 24'h000000};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("reset_ringing", 32'(ringing), 0);
        chk("reset_snoozed", 32'(snoozed), 0);
        chk("reset_wr_err", 32'(wr_err), 0);
        for (int i = 0; i < N; i++) begin
            rd_idx = IDX_W'(i);
            #1;
            chk("reset_rd", 32'({rd_hour, rd_min, rd_sec}), 0);
        end

        // Write-validation table
        for (int v = 0; v < 13; v++) begin
            rd_idx = IDX_W'(wv[v].rdi);
            wr(wv[v].idx, wv[v].field, wv[v].data);
            chk("tbl_wr_err", 32'(wr_err), 32'(wv[v].exp_err));
            chk("tbl_rd", 32'({rd_hour, rd_min, rd_sec}), 32'(wv[v].exp_rd));
            $display("vec %0d: idx=%0d field=%0d data=%02h wr_err=%0b rd=%02h:%02h:%02h",
                     v, wv[v].idx, wv[v].field, wv[v].data, wr_err, rd_hour, rd_min, rd_sec);
        end
        cyc();
        chk("wr_err_one_cycle", 32'(wr_err), 0);

        // Basic ring and auto-stop
        alarm_en = 5'b00100;
        tick_at(8'h07, 8'h30, 8'h00);
        chk("ring_start", 32'(ringing), 32'(5'b00100));
        ticks(RING - 1);
        chk("ring_before_autostop", 32'(ringing), 32'(5'b00100));
        ticks(1);
        chk("ring_autostop", 32'(ringing), 0);
        $display("seq ring/autostop done");

        // Snooze cycle with repeat limit
        set_alarm(0, 8'h06, 8'h00, 8'h00);
        alarm_en = 5'b00001;
        tick_at(8'h06, 8'h00, 8'h00);
        chk("snz_ring_start", 32'(ringing), 1);
        for (int k = 0; k < MAXS; k++) begin
            snooze = 1'b1; cyc(); snooze = 1'b0;
            chk("snz_snoozed", 32'(snoozed), 1);
            chk("snz_not_ringing", 32'(ringing), 0);
            ticks(SNZ - 1);
            chk("snz_still_snoozed", 32'(snoozed), 1);
            ticks(1);
            chk("snz_reringing", 32'(ringing), 1);
            $display("seq snooze %0d done", k + 1);
        end
        snooze = 1'b1; cyc(); snooze = 1'b0;
        chk("snz_limit_ignored", 32'(ringing), 1);
        chk("snz_limit_not_snoozed", 32'(snoozed), 0);
        ticks(RING - 1);
        chk("snz_limit_still_ring", 32'(ringing), 1);
        ticks(1);
        chk("snz_limit_autostop", 32'(ringing), 0);

        // Simultaneous ring, stop, disable
        set_alarm(4, 8'h06, 8'h00, 8'h00);
        alarm_en = 5'b10001;
        tick_at(8'h06, 8'h00, 8'h00);
        chk("dual_ring", 32'(ringing), 32'(5'b10001));
        stop = 1'b1; cyc(); stop = 1'b0;
        chk("dual_stop", 32'(ringing), 0);
        tick_at(8'h06, 8'h00, 8'h00);
        chk("dual_reret", 32'(ringing), 32'(5'b10001));
        alarm_en = 5'b00001;
        cyc();
        chk("disable_4", 32'(ringing), 32'(5'b00001));

        // Snooze and tick in the same cycle, then write to a ringing channel
        snooze = 1'b1; tick_1s = 1'b1; cyc(); snooze = 1'b0; tick_1s = 1'b0;
        chk("snz_tick_snoozed", 32'(snoozed), 1);
        ticks(SNZ - 1);
        chk("snz_tick_still", 32'(snoozed), 1);
        ticks(1);
        chk("snz_tick_rering", 32'(ringing), 1);
        wr(0, 2, 8'h01);
        chk("write_stops_ring", 32'(ringing), 0);
        $display("seq snooze+tick / write-stop done");

        // Asynchronous reset mid-ring
        alarm_en = 5'b00101;
        tick_at(8'h07, 8'h30, 8'h00);
        chk("pre_reset_ring", 32'(ringing), 32'(5'b00100));
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset_ring", 32'(ringing), 0);
        rd_idx = 3'd2;
        #1;
        chk("async_reset_rd", 32'({rd_hour, rd_min, rd_sec}), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        $display("seq async reset done");

        // Randomized run
        alarm_en = '1;
        for (int c = 0; c < 4000; c++) begin
            int ch;
            wr_en = ($urandom_range(0, 7) == 0);
            wr_idx = IDX_W'($urandom_range(0, 7));
            wr_field = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0)
                wr_data = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            else
                wr_data = 8'($urandom);
            if ($urandom_range(0, 63) == 0) alarm_en[$urandom_range(0, N - 1)] ^= 1'b1;
            snooze = ($urandom_range(0, 19) == 0);
            stop = ($urandom_range(0, 79) == 0);
            tick_1s = ($urandom_range(0, 1) == 0);
            ch = $urandom_range(0, N - 1);
            if ($urandom_range(0, 3) == 0) begin
                cur_hour = 8'(m_t[ch][0]); cur_min = 8'(m_t[ch][1]); cur_sec = 8'(m_t[ch][2]);
            end else begin
                cur_hour = 8'($urandom); cur_min = 8'($urandom); cur_sec = 8'($urandom);
            end
            rd_idx = IDX_W'($urandom_range(0, 7));
            cyc();
        end
        wr_en = 1'b0; snooze = 1'b0; stop = 1'b0; tick_1s = 1'b0;
        $display("random phase done: ringing=%b snoozed=%b", ringing, snoozed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
